// File: rtl/hamming_pkg.sv
// Shared types and helpers for the SECDED Hamming stream decoder.
// Latency: not applicable (types and constant functions only).
// Backpressure: not applicable.
package hamming_pkg;

  // Error classes reported with every decoded word.
  typedef enum logic [1:0] {
    ERR_NONE        = 2'b00,
    ERR_SINGLE      = 2'b01,
    ERR_OVERALL_PAR = 2'b10,
    ERR_UNCORR      = 2'b11
  } err_type_e;

  // Number of Hamming check bits for a given payload width.
  function automatic int parity_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

  // Full encoded width: payload, check bits and the overall parity bit.
  function automatic int enc_width(input int data_width);
    return data_width + parity_width(data_width) + 1;
  endfunction

  // Check bits live at power-of-two Hamming positions.
  function automatic logic is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// Combinational syndrome and overall-parity computation for one encoded word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result when its stage advances.
module hamming_syndrome_calc
  import hamming_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  localparam int PARITY_WIDTH = parity_width(DATA_WIDTH),
  localparam int ENC_WIDTH    = enc_width(DATA_WIDTH)
) (
  input  logic [ENC_WIDTH-1:0]    enc_data,
  output logic [PARITY_WIDTH-1:0] syndrome,
  output logic                    overall
);

  localparam int CODE_LEN = DATA_WIDTH + PARITY_WIDTH;

  // Syndrome is the XOR of the Hamming positions of every set bit.
  always_comb begin
    syndrome = '0;
    for (int p = 1; p <= CODE_LEN; p++) begin
      if (enc_data[p-1]) begin
        syndrome = syndrome ^ PARITY_WIDTH'(p);
      end
    end
  end

  // Overall parity covers the whole word including the overall bit itself.
  assign overall = ^enc_data;

endmodule

// File: rtl/hamming_secded_stream_decoder.sv
// SECDED Hamming stream decoder: classifies, optionally corrects, reports syndrome, counts errors.
// Latency: 2 cycles from input handshake to o_valid when unstalled; 1 word per cycle.
// Backpressure: per-stage enables collapse bubbles; o_ready drops only with both stages full and i_ready low.
module hamming_secded_stream_decoder
  import hamming_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int CNT_WIDTH    = 16,
  localparam int PARITY_WIDTH = parity_width(DATA_WIDTH),
  localparam int ENC_WIDTH    = enc_width(DATA_WIDTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [ENC_WIDTH-1:0]    i_enc_data,
  input  logic                    i_corr_en,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [1:0]              o_err_type,
  output logic [PARITY_WIDTH-1:0] o_syndrome,
  input  logic                    i_cnt_clr,
  output logic [CNT_WIDTH-1:0]    o_single_cnt,
  output logic [CNT_WIDTH-1:0]    o_uncorr_cnt,
  output logic                    o_uncorr_sticky
);

  localparam int CODE_LEN = DATA_WIDTH + PARITY_WIDTH;

  // Stage 1: raw word (overall bit dropped, its effect is captured in s1_q).
  logic                    s1_v;
  logic [CODE_LEN-1:0]     s1_word;
  logic [PARITY_WIDTH-1:0] s1_syn;
  logic                    s1_q;
  logic                    s1_corr;

  // Stage 2 state drives the outputs directly.
  logic                    s2_v;
  logic [DATA_WIDTH-1:0]   s2_data;
  err_type_e               s2_type;
  logic [PARITY_WIDTH-1:0] s2_syn;

  logic                    s1_en;
  logic                    s2_en;
  logic                    out_hs;

  logic [PARITY_WIDTH-1:0] in_syn;
  logic                    in_q;

  err_type_e               cls;
  logic                    do_flip;
  logic [CODE_LEN-1:0]     word_fix;
  logic [DATA_WIDTH-1:0]   ext_data;

  logic [CNT_WIDTH-1:0]    single_cnt;
  logic [CNT_WIDTH-1:0]    uncorr_cnt;
  logic                    uncorr_sticky;

  // A stage advances when it is empty or its successor advances.
  assign s2_en   = !s2_v || i_ready;
  assign s1_en   = !s1_v || s2_en;
  assign o_ready = s1_en;
  assign out_hs  = s2_v && i_ready;

  hamming_syndrome_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_syndrome_calc (
    .enc_data (i_enc_data),
    .syndrome (in_syn),
    .overall  (in_q)
  );

  // Stage 1 register: capture the word with its syndrome, parity and mode bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v    <= 1'b0;
      s1_word <= '0;
      s1_syn  <= '0;
      s1_q    <= 1'b0;
      s1_corr <= 1'b0;
    end else if (s1_en) begin
      s1_v <= i_valid;
      if (i_valid) begin
        s1_word <= i_enc_data[CODE_LEN-1:0];
        s1_syn  <= in_syn;
        s1_q    <= in_q;
        s1_corr <= i_corr_en;
      end
    end
  end

  // Classify from syndrome and overall parity; out-of-range syndromes are uncorrectable.
  always_comb begin
    cls = ERR_NONE;
    if (s1_syn == '0) begin
      cls = s1_q ? ERR_OVERALL_PAR : ERR_NONE;
    end else if (!s1_q) begin
      cls = ERR_UNCORR;
    end else if (s1_syn > PARITY_WIDTH'(CODE_LEN)) begin
      cls = ERR_UNCORR;
    end else begin
      cls = ERR_SINGLE;
    end
  end

  // Detect-only mode keeps classification but suppresses the flip.
  assign do_flip = s1_corr && (cls == ERR_SINGLE);

  // Apply the flip at position s, then gather data bits from non-power-of-two positions.
  always_comb begin
    int di;
    di       = 0;
    word_fix = s1_word;
    ext_data = '0;
    for (int p = 1; p <= CODE_LEN; p++) begin
      if (do_flip && (s1_syn == PARITY_WIDTH'(p))) begin
        word_fix[p-1] = ~s1_word[p-1];
      end
      if (!is_pow2(p)) begin
        ext_data[di] = word_fix[p-1];
        di = di + 1;
      end
    end
  end

  // Stage 2 register: results only change when the stage advances, so stalls hold them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_v    <= 1'b0;
      s2_data <= '0;
      s2_type <= ERR_NONE;
      s2_syn  <= '0;
    end else if (s2_en) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_data <= ext_data;
        s2_type <= cls;
        s2_syn  <= s1_syn;
      end
    end
  end

  // Saturating statistics on delivered words; clear takes priority over counting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      single_cnt    <= '0;
      uncorr_cnt    <= '0;
      uncorr_sticky <= 1'b0;
    end else if (i_cnt_clr) begin
      single_cnt    <= '0;
      uncorr_cnt    <= '0;
      uncorr_sticky <= 1'b0;
    end else if (out_hs) begin
      if ((s2_type == ERR_SINGLE) || (s2_type == ERR_OVERALL_PAR)) begin
        if (single_cnt != '1) begin
          single_cnt <= single_cnt + 1'b1;
        end
      end else if (s2_type == ERR_UNCORR) begin
        if (uncorr_cnt != '1) begin
          uncorr_cnt <= uncorr_cnt + 1'b1;
        end
        uncorr_sticky <= 1'b1;
      end
    end
  end

  assign o_valid         = s2_v;
  assign o_data          = s2_data;
  assign o_err_type      = s2_type;
  assign o_syndrome      = s2_syn;
  assign o_single_cnt    = single_cnt;
  assign o_uncorr_cnt    = uncorr_cnt;
  assign o_uncorr_sticky = uncorr_sticky;

endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Directed self-checking bench for the SECDED stream decoder (DATA_WIDTH=8, CNT_WIDTH=2).
// Latency: checks 2-cycle input-to-output timing and stall behaviour.
// Backpressure: exercised by holding i_ready low with both stages full.
module tb_hamming_secded_stream_decoder;

  localparam int DW = 8;
  localparam int PW = 4;
  localparam int EW = 13;
  localparam int CW = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [EW-1:0] i_enc_data = '0;
  logic          i_corr_en = 1'b1;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [DW-1:0] o_data;
  logic [1:0]    o_err_type;
  logic [PW-1:0] o_syndrome;
  logic          i_cnt_clr = 1'b0;
  logic [CW-1:0] o_single_cnt;
  logic [CW-1:0] o_uncorr_cnt;
  logic          o_uncorr_sticky;

  int n_cmp = 0;
  int n_err = 0;

  hamming_secded_stream_decoder #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_enc_data      (i_enc_data),
    .i_corr_en       (i_corr_en),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_data          (o_data),
    .o_err_type      (o_err_type),
    .o_syndrome      (o_syndrome),
    .i_cnt_clr       (i_cnt_clr),
    .o_single_cnt    (o_single_cnt),
    .o_uncorr_cnt    (o_uncorr_cnt),
    .o_uncorr_sticky (o_uncorr_sticky)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Push one word with i_ready high and check timing, payload, class and syndrome.
  task automatic decode1(input string tag, input logic [EW-1:0] enc, input logic corr,
                         input logic [DW-1:0] exp_d, input logic [1:0] exp_t,
                         input logic [PW-1:0] exp_s);
    i_valid    = 1'b1;
    i_enc_data = enc;
    i_corr_en  = corr;
    chk({tag, "_rdy"}, o_ready, 1);
    tick();
    i_valid = 1'b0;
    chk({tag, "_vld_c1"}, o_valid, 0);
    tick();
    chk({tag, "_vld_c2"}, o_valid, 1);
    chk({tag, "_data"}, o_data, exp_d);
    chk({tag, "_type"}, o_err_type, exp_t);
    chk({tag, "_syn"}, o_syndrome, exp_s);
    tick();
    chk({tag, "_vld_end"}, o_valid, 0);
  endtask

  initial begin
    // Reset state.
    #2;
    chk("rst_vld", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_type", o_err_type, 0);
    chk("rst_syn", o_syndrome, 0);
    chk("rst_scnt", o_single_cnt, 0);
    chk("rst_ucnt", o_uncorr_cnt, 0);
    chk("rst_sticky", o_uncorr_sticky, 0);
    chk("rst_rdy", o_ready, 1);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Main decode vectors with correction enabled.
    decode1("none", 13'h0F77, 1'b1, 8'hFF, 2'b00, 4'd0);
    chk("none_scnt", o_single_cnt, 0);
    decode1("single", 13'h0004, 1'b1, 8'h00, 2'b01, 4'd3);
    chk("single_scnt", o_single_cnt, 1);
    decode1("ovp", 13'h1000, 1'b1, 8'h00, 2'b10, 4'd0);
    chk("ovp_scnt", o_single_cnt, 2);
    decode1("dbl", 13'h0014, 1'b1, 8'h03, 2'b11, 4'd6);
    chk("dbl_sticky", o_uncorr_sticky, 1);
    chk("dbl_ucnt", o_uncorr_cnt, 1);
    decode1("oor", 13'h0089, 1'b1, 8'h00, 2'b11, 4'd13);
    chk("oor_ucnt", o_uncorr_cnt, 2);
    decode1("fix9", 13'h0E77, 1'b1, 8'hFF, 2'b01, 4'd9);
    chk("fix9_scnt", o_single_cnt, 3);

    // Detect-only: same error, raw data passes, count saturates at 3.
    decode1("det", 13'h0E77, 1'b0, 8'hEF, 2'b01, 4'd9);
    chk("det_scnt_sat", o_single_cnt, 3);
    decode1("sat5", 13'h0004, 1'b1, 8'h00, 2'b01, 4'd3);
    chk("sat5_scnt", o_single_cnt, 3);
    chk("sat5_ucnt", o_uncorr_cnt, 2);

    // Clear coincident with a SINGLE output handshake.
    i_valid    = 1'b1;
    i_enc_data = 13'h0004;
    i_corr_en  = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    chk("clr_vld", o_valid, 1);
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
    chk("clr_scnt", o_single_cnt, 0);
    chk("clr_ucnt", o_uncorr_cnt, 0);
    chk("clr_sticky", o_uncorr_sticky, 0);

    // Backpressure: two words accepted, third refused, outputs held.
    i_ready    = 1'b0;
    i_valid    = 1'b1;
    i_enc_data = 13'h0F77;
    chk("bp_rdy_a", o_ready, 1);
    tick();
    i_enc_data = 13'h0004;
    chk("bp_rdy_b", o_ready, 1);
    tick();
    i_enc_data = 13'h1000;
    chk("bp_rdy_c", o_ready, 0);
    chk("bp_vld", o_valid, 1);
    chk("bp_data_a", o_data, 8'hFF);
    tick();
    chk("bp_rdy_hold", o_ready, 0);
    chk("bp_data_hold", o_data, 8'hFF);
    chk("bp_type_hold", o_err_type, 2'b00);
    chk("bp_syn_hold", o_syndrome, 0);
    i_ready = 1'b1;
    #1;
    chk("bp_rdy_rel", o_ready, 1);
    tick();
    i_valid = 1'b0;
    chk("bp_b_vld", o_valid, 1);
    chk("bp_b_data", o_data, 8'h00);
    chk("bp_b_type", o_err_type, 2'b01);
    chk("bp_b_syn", o_syndrome, 3);
    tick();
    chk("bp_c_vld", o_valid, 1);
    chk("bp_c_type", o_err_type, 2'b10);
    chk("bp_c_syn", o_syndrome, 0);
    tick();
    chk("bp_end_vld", o_valid, 0);
    chk("bp_scnt", o_single_cnt, 2);

    // Reset with both stages full.
    i_ready    = 1'b0;
    i_valid    = 1'b1;
    i_enc_data = 13'h0004;
    tick();
    i_enc_data = 13'h0014;
    tick();
    i_valid = 1'b0;
    chk("mr_full_rdy", o_ready, 0);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("mr_vld", o_valid, 0);
    chk("mr_scnt", o_single_cnt, 0);
    chk("mr_data", o_data, 0);
    chk("mr_rdy", o_ready, 1);
    tick();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    tick();
    chk("mr_post_vld", o_valid, 0);
    decode1("post", 13'h0F77, 1'b1, 8'hFF, 2'b00, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
